// File: rtl/dcache_fill_ctrl.sv
// dcache_fill_ctrl: miss/fill controller owning valid bits, victim choice and the line fill handshake of a 3-way 8-set tag bank
module dcache_fill_ctrl #(
   parameter int NWAYS = 3,
   parameter int NSETS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [14:0]      req_addr,
   input  logic             flush,
   input  logic             hit,
   input  logic [1:0]       hit_way,
   input  logic             mem_ack,
   output logic [14:0]      tag_addr,
   output logic [NWAYS-1:0] valid,
   output logic [1:0]       update_way,
   output logic             mem_wren,
   output logic             mem_req,
   output logic [14:0]      mem_addr,
   output logic             stall,
   output logic             resp_hit,
   output logic [1:0]       resp_way
);
   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
   state_t state, state_nxt;
   logic [NSETS-1:0][NWAYS-1:0] valid_r;
   logic [NSETS-1:0][1:0] rr_ptr;
   logic [14:0] miss_addr;
   logic [1:0] victim, victim_nxt;
   logic [2:0] req_set, miss_set;
   logic [NWAYS-1:0] set_valid;
   logic miss_full;
   assign req_set = req_addr[5:3];
   assign miss_set = miss_addr[5:3];
   assign tag_addr = (state == IDLE) ? req_addr : miss_addr;
   assign valid = valid_r[tag_addr[5:3]];
   assign set_valid = valid_r[req_set];
   assign victim_nxt = !set_valid[0] ? 2'd0 : !set_valid[1] ? 2'd1 : !set_valid[2] ? 2'd2 : rr_ptr[req_set];
   // A set that was full at miss time stays full until its fill, so fullness here means the victim came from rr_ptr
   assign miss_full = &valid_r[miss_set];
   assign update_way = victim;
   assign mem_addr = {miss_addr[14:3], 3'b000};
   assign resp_way = hit_way;
   // State register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   // Next state and handshake outputs; outside IDLE everything is decoded from state alone
   always_comb begin
      state_nxt = state;
      stall = 1'b1;
      resp_hit = 1'b0;
      mem_req = 1'b0;
      mem_wren = 1'b0;
      unique case (state)
         IDLE: begin
            stall = flush | (req_valid & ~hit);
            resp_hit = ~flush & req_valid & hit;
            if (!flush && req_valid && !hit) state_nxt = REQ;
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_ack) state_nxt = FILL;
         end
         FILL: begin
            mem_wren = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // Valid bits, round-robin pointers and the latched miss
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid_r <= '0;
         rr_ptr <= '0;
         miss_addr <= '0;
         victim <= '0;
      end else if (state == IDLE && flush) begin
         valid_r <= '0;
         rr_ptr <= '0;
      end else if (state == IDLE && req_valid && !hit) begin
         miss_addr <= req_addr;
         victim <= victim_nxt;
      end else if (state == FILL) begin
         valid_r[miss_set][victim] <= 1'b1;
         if (miss_full) rr_ptr[miss_set] <= (rr_ptr[miss_set] == 2'd2) ? 2'd0 : rr_ptr[miss_set] + 2'd1;
      end
endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// tb_dcache_fill_ctrl: scoreboard bench with a tag-bank model and a per-set reference model of the fill controller
module tb_dcache_fill_ctrl;
   logic clk = 0, rst = 1, req_valid = 0, flush = 0, hit, mem_ack = 0;
   logic [14:0] req_addr = '0, tag_addr, mem_addr;
   logic [1:0] hit_way, update_way, resp_way;
   logic [2:0] valid;
   logic mem_wren, mem_req, stall, resp_hit;
   int checks = 0, errors = 0;
   typedef struct {bit fill; logic [1:0] way; logic [14:0] addr;} ev_t;
   ev_t q[$];
   bit mvalid[8][3];
   logic [6:0] mtag[8][3];
   int mrr[8];
   logic [6:0] bank_tag[8][3];

   dcache_fill_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
      .hit(hit), .hit_way(hit_way), .mem_ack(mem_ack), .tag_addr(tag_addr), .valid(valid),
      .update_way(update_way), .mem_wren(mem_wren), .mem_req(mem_req), .mem_addr(mem_addr),
      .stall(stall), .resp_hit(resp_hit), .resp_way(resp_way)
   );

   always #5 clk = ~clk;

   // Tag bank: stores tags on mem_wren, hits on a valid way whose tag matches
   always @(posedge clk) if (mem_wren) bank_tag[tag_addr[5:3]][update_way] <= tag_addr[14:8];
   always_comb begin
      hit = 1'b0;
      hit_way = 2'd0;
      for (int w = 0; w < 3; w++)
         if (valid[w] && bank_tag[tag_addr[5:3]][w] == tag_addr[14:8]) begin
            hit = 1'b1;
            hit_way = 2'(w);
         end
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] mset(input int s);
      return {mvalid[s][2], mvalid[s][1], mvalid[s][0]};
   endfunction

   task automatic clear_model();
      foreach (mvalid[s, w]) mvalid[s][w] = 0;
      foreach (mrr[s]) mrr[s] = 0;
   endtask

   // Monitor: every fill strobe and every completed hit pops one expected event
   always @(negedge clk) if (!rst) begin
      ev_t e;
      if (mem_wren) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fill_unexpected: way %0d addr %0h with empty queue", update_way, mem_addr);
         end else begin
            e = q.pop_front();
            chk("fill_kind", 32'(e.fill), 32'(1));
            chk("fill_way", 32'(update_way), 32'(e.way));
            chk("fill_addr", 32'(mem_addr), 32'(e.addr));
         end
      end
      if (resp_hit) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL hit_unexpected: way %0d with empty queue", resp_way);
         end else begin
            e = q.pop_front();
            chk("hit_kind", 32'(e.fill), 32'(0));
            chk("hit_way", 32'(resp_way), 32'(e.way));
         end
      end
   end

   // One lookup: a hit completes at once, a miss runs REQ for d+1 cycles, one FILL, then re-hits
   task automatic do_req(input logic [14:0] a, input int d, input bit hf);
      int s, v;
      bit h, full;
      s = int'(a[5:3]);
      h = 0;
      v = 0;
      for (int w = 0; w < 3; w++) if (mvalid[s][w] && mtag[s][w] == a[14:8]) begin h = 1; v = w; end
      req_valid = 1;
      req_addr = a;
      if (h) begin
         q.push_back('{fill: 0, way: 2'(v), addr: '0});
         @(negedge clk);
         chk("hit_stall", 32'(stall), 32'(0));
         chk("hit_valid", 32'(valid), 32'(mset(s)));
         @(posedge clk); #1;
         req_valid = 0;
      end else begin
         full = mvalid[s][0] && mvalid[s][1] && mvalid[s][2];
         v = !mvalid[s][0] ? 0 : !mvalid[s][1] ? 1 : !mvalid[s][2] ? 2 : mrr[s];
         q.push_back('{fill: 1, way: 2'(v), addr: {a[14:3], 3'b000}});
         q.push_back('{fill: 0, way: 2'(v), addr: '0});
         @(negedge clk);
         chk("miss_stall", 32'(stall), 32'(1));
         chk("miss_valid", 32'(valid), 32'(mset(s)));
         @(posedge clk); #1;
         flush = hf;
         for (int i = 0; i <= d; i++) begin
            if (i == d) mem_ack = 1;
            @(negedge clk);
            chk("req_mem_req", 32'(mem_req), 32'(1));
            chk("req_mem_addr", 32'(mem_addr), 32'({a[14:3], 3'b000}));
            @(posedge clk); #1;
         end
         mem_ack = 0;
         flush = 0;
         @(negedge clk);
         chk("fill_stall", 32'(stall), 32'(1));
         @(posedge clk); #1;
         mvalid[s][v] = 1;
         mtag[s][v] = a[14:8];
         if (full) mrr[s] = (mrr[s] + 1) % 3;
         @(negedge clk);
         chk("rehit_stall", 32'(stall), 32'(0));
         chk("rehit_valid", 32'(valid), 32'(mset(s)));
         @(posedge clk); #1;
         req_valid = 0;
      end
   endtask

   task automatic do_flush();
      flush = 1;
      req_valid = 0;
      @(negedge clk);
      chk("flush_stall", 32'(stall), 32'(1));
      @(posedge clk); #1;
      flush = 0;
      clear_model();
   endtask

   initial begin
      logic [14:0] a;
      clear_model();
      #2;
      chk("rst_mem_req", 32'(mem_req), 32'(0));
      chk("rst_mem_wren", 32'(mem_wren), 32'(0));
      chk("rst_resp_hit", 32'(resp_hit), 32'(0));
      chk("rst_update_way", 32'(update_way), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_stall_idle", 32'(stall), 32'(0));
      req_valid = 1;
      req_addr = 15'h1A28;
      #1;
      chk("rst_stall_req", 32'(stall), 32'(1));
      chk("rst_valid", 32'(valid), 32'(0));
      req_valid = 0;
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      do_req(15'h1A28, 3, 0);
      for (int t = 0; t < 7; t++) do_req(15'({7'(8'h40 + t), 2'b00, 3'd2, 3'b000}), t % 3, 0);
      do_req(15'h2220, 0, 0);
      do_req(15'h1A28, 0, 0);
      do_req(15'h4210, 1, 0);
      flush = 1;
      req_valid = 1;
      req_addr = 15'h1A28;
      @(negedge clk);
      chk("flushpri_resp_hit", 32'(resp_hit), 32'(0));
      chk("flushpri_stall", 32'(stall), 32'(1));
      @(posedge clk); #1;
      flush = 0;
      clear_model();
      do_req(15'h1A28, 1, 1);
      do_req(15'h1A28, 0, 0);
      a = 15'h5518;
      req_valid = 1;
      req_addr = a;
      @(posedge clk); #1;
      chk("rstreq_mem_req_before", 32'(mem_req), 32'(1));
      rst = 1;
      #1;
      chk("rstreq_mem_req_after", 32'(mem_req), 32'(0));
      @(negedge clk);
      rst = 0;
      clear_model();
      #1;
      chk("rstreq_valid", 32'(valid), 32'(0));
      chk("rstreq_stall", 32'(stall), 32'(1));
      req_valid = 0;
      @(posedge clk); #1;
      a = 15'h3330;
      req_valid = 1;
      req_addr = a;
      @(posedge clk); #1;
      mem_ack = 1;
      @(posedge clk); #1;
      mem_ack = 0;
      chk("rstfill_mem_wren_before", 32'(mem_wren), 32'(1));
      rst = 1;
      #1;
      chk("rstfill_mem_wren_after", 32'(mem_wren), 32'(0));
      @(negedge clk);
      rst = 0;
      #1;
      chk("rstfill_valid", 32'(valid), 32'(0));
      req_valid = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 11) == 0) do_flush();
         else do_req(15'({7'($urandom_range(16, 19)), 2'($urandom), 3'($urandom_range(0, 3)), 3'($urandom)}),
                     int'($urandom_range(0, 3)), 1'($urandom));
      end
      repeat (3) @(posedge clk);
      chk("queue_empty", 32'(q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dcache_fill_ctrl.md
# dcache_fill_ctrl

Miss/fill controller for the 3-way, 8-set data-cache tag bank. It sits directly upstream of the tag bank and owns everything the bank does not: per-set valid bits, victim-way selection, the tag write-enable, and the memory fill handshake. It consumes the bank's `hit`/`hit_way` result and drives its `addr`, `update_way`, `mem_wren` and `valid` inputs. It stalls the pipeline from a miss until the line is filled and re-looked-up.

## Interface
- `NWAYS`, 3: ways per set (fixed; logic is written for 3).
- `NSETS`, 8: sets, indexed by `addr[5:3]`.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: a load/store lookup is presented this cycle.
- `req_addr` input 15: lookup address; tag = [14:8], set = [5:3], line offset = [2:0].
- `flush` input 1: invalidate all lines (level, sampled in IDLE).
- `hit` input 1: from the tag bank, combinational on `tag_addr`/`valid`.
- `hit_way` input 2: from the tag bank; meaningful only when `hit`=1.
- `mem_ack` input 1: memory has returned the line for `mem_addr`.
- `tag_addr` output 15: address to the tag bank.
- `valid` output 3: valid bits of set `tag_addr[5:3]`, bit i = way i.
- `update_way` output 2: way to write (0..2; never 3).
- `mem_wren` output 1: tag/data write strobe to the tag and data banks.
- `mem_req` output 1: line fetch request.
- `mem_addr` output 15: `{miss_addr[14:3],3'b000}`.
- `stall` output 1: the pipeline must hold `req_*`.
- `resp_hit` output 1: the lookup completed as a hit this cycle.
- `resp_way` output 2: way of the completed hit.

## Operation
- **State:**
  - `valid_r[8][3]`.
  - `rr_ptr[8]` (2 bits each, values 0..2).
  - `miss_addr[15]`.
  - `victim[2]`.
  - FSM states IDLE, REQ, FILL.
- **Address to the bank:** `tag_addr` = `req_addr` in IDLE, `miss_addr` otherwise.
- **IDLE:**
  - If `flush`=1: clear all `valid_r` and all `rr_ptr` at the edge, with `stall`=1 and `resp_hit`=0. This takes priority over `req_valid`; the request is re-evaluated the next cycle.
  - Else if `req_valid` && `hit`: `resp_hit`=1, `resp_way`=`hit_way`, `stall`=0, stay in IDLE.
  - Else if `req_valid` && !`hit`: `stall`=1, latch `miss_addr`=`req_addr`, latch the victim, go to REQ.
  - Victim selection: the lowest-numbered invalid way of the set if any; otherwise `rr_ptr[set]`.
- **REQ:**
  - `mem_req`=1; `mem_addr` is stable and derived from `miss_addr`.
  - Stay until `mem_ack`=1 is sampled, then go to FILL. An ack in the first REQ cycle is legal.
- **FILL:** exactly one cycle.
  - Outputs: `mem_wren`=1, `update_way`=`victim`, `stall`=1.
  - At the edge: `valid_r[set][victim]`←1. If the victim came from `rr_ptr` (set was full), `rr_ptr[set]` ← (`rr_ptr`+1) mod 3, i.e. 2→0. Then go to IDLE.
- **Re-lookup:** in the cycle after FILL, the still-held request hits.
- **update_way outside FILL:** equals `victim` (stable, don't-care to the bank because `mem_wren`=0).
- **Ignored inputs:** `flush` and `req_valid` are ignored in REQ/FILL. `hit` is ignored outside IDLE.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - State IDLE; `valid_r`=0, `rr_ptr`=0, `miss_addr`=0, `victim`=0.
  - `mem_req`=0, `mem_wren`=0, `resp_hit`=0, `update_way`=0, `mem_addr`=0.
  - `stall` = `req_valid` (a miss, since `valid`=0).
- **Reset mid-REQ or mid-FILL:** the request is abandoned and no valid bit is set. Memory must tolerate `mem_req` dropping without an ack.
- **Hit latency:** 0 cycles; `resp_hit` is combinational in the presentation cycle.
- **Miss latency:** presentation cycle (IDLE) + N≥1 REQ cycles + 1 FILL cycle, then a hit in the following cycle. The minimum is a 4-cycle occupancy with `mem_ack` in the first REQ cycle.
- **Output sources:** `mem_req`, `mem_wren` and `stall` outside IDLE are decoded from state only (no combinational path from `mem_ack`).
- **Pipeline handshake:** `req_addr` must be held while `stall`=1. A new request is accepted when `stall`=0.

## Test plan
- **Cold miss then hit:** after reset, `req_addr`=15'h1A28 (tag 0x1A, set 5), bank `hit`=0.
  - Expect: REQ with `mem_addr`=15'h1A28; ack after 3 cycles; one FILL cycle with `mem_wren`=1, `update_way`=0; next cycle `valid`=3'b001 and `resp_hit`=1.
- **Fill order:** three distinct-tag misses to set 2.
  - Expect: victims 0, 1, 2 and `valid`=3'b111, with `rr_ptr[2]` still 0.
  - A 4th miss takes way 0, a 5th way 1, a 6th way 2, and a 7th way 0 again (wrap 2→0).
- **Same-cycle ack and set isolation:** `mem_ack`=1 in the first REQ cycle.
  - Expect: FILL on the next cycle, total occupancy 4 cycles.
  - Sets other than the miss set keep their `valid`.
- **Flush priority:** `flush`=1 together with a hitting `req_valid` in IDLE.
  - Expect: `resp_hit`=0 and `stall`=1 in that cycle; then all `valid` reads 0 and the request misses.
  - A `flush` held during REQ has no effect until IDLE.
- **Reset mid-operation:** assert `rst` while in REQ.
  - Expect: `mem_req` drops in the same cycle; after release, state is IDLE and `valid` of the set is 3'b000.
  - Assert `rst` during FILL: the way does not become valid.
- **Invalid-first victim:** set 7 with `valid`=3'b101 and `rr_ptr`=2; miss.
  - Expect: victim 1 and `rr_ptr` unchanged.
